// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared shift datapath, one bit per cycle,
// fixed latency for every funct3 and every special case.
module rv32m_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Handshake: start is sampled only while idle (busy=0); busy rises on the accept edge
    // and stays high through the single done cycle; result/rd_out are valid while done=1
    // and held until the next operation finishes. start during busy is dropped.
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic            fin;
    logic [2:0]      op;
    logic [4:0]      rd_lat;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            neg_res;
    logic            neg_rem;
    logic            div_zero;
    logic            ovf;

    // Operand decode at accept time
    logic            in_a_signed, in_b_signed, in_neg_a, in_neg_b, in_ovf;
    logic [XLEN-1:0] in_a_mag, in_b_mag;

    always_comb begin
        in_a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        in_b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        in_neg_a    = in_a_signed && rs1_val[XLEN-1];
        in_neg_b    = in_b_signed && rs2_val[XLEN-1];
        in_a_mag    = in_neg_a ? -rs1_val : rs1_val;
        in_b_mag    = in_neg_b ? -rs2_val : rs2_val;
        in_ovf      = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                      (rs1_val == MIN_NEG) && (rs2_val == {XLEN{1'b1}});
    end

    // One iteration of the shared datapath: {hi,lo} shifts right for multiply, left for divide
    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_r;
    logic [XLEN:0] div_diff;

    always_comb begin
        mul_sum  = {1'b0, hi} + {1'b0, a_mag};
        div_r    = {hi, lo[XLEN-1]};
        div_diff = div_r - {1'b0, b_mag};
    end

    // Sign correction and special-case selection for the final result
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   dz_rem;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod   = {hi, lo};
        prod_s = neg_res ? -prod : prod;
        quot_s = neg_res ? -lo : lo;
        rem_s  = neg_rem ? -hi : hi;
        dz_rem = neg_rem ? -a_mag : a_mag;
        final_res = '0;
        case (op)
            3'd0:                final_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_res = div_zero ? {XLEN{1'b1}} : (ovf ? MIN_NEG : quot_s);
            default:             final_res = div_zero ? dz_rem : (ovf ? '0 : rem_s);
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            counter  <= '0;
            fin      <= 1'b0;
            op       <= '0;
            rd_lat   <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            hi       <= '0;
            lo       <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            rd_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op       <= funct3;
                        rd_lat   <= rd_addr;
                        a_mag    <= in_a_mag;
                        b_mag    <= in_b_mag;
                        hi       <= '0;
                        lo       <= funct3[2] ? in_a_mag : in_b_mag;
                        neg_res  <= in_neg_a ^ in_neg_b;
                        neg_rem  <= in_neg_a;
                        div_zero <= (rs2_val == '0);
                        ovf      <= in_ovf;
                        counter  <= CW'(XLEN-1);
                        fin      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // After the last iteration one more edge registers the corrected result
                    if (fin) begin
                        result <= final_res;
                        rd_out <= rd_lat;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        if (op[2]) begin
                            if (!div_diff[XLEN]) begin
                                hi <= div_diff[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b1};
                            end else begin
                                hi <= div_r[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b0};
                            end
                        end else if (lo[0]) begin
                            hi <= mul_sum[XLEN:1];
                            lo <= {mul_sum[0], lo[XLEN-1:1]};
                        end else begin
                            hi <= {1'b0, hi[XLEN-1:1]};
                            lo <= {hi[0], lo[XLEN-1:1]};
                        end
                        if (counter == '0) fin <= 1'b1;
                        else               counter <= counter - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed bench for rv32m_muldiv_unit: hand-computed RV32M vectors, latency, busy/done
// protocol, start-while-busy, and asynchronous reset during an operation.
module tb_rv32m_muldiv_unit;

    localparam int XLEN = 32;

    logic            CLK;
    logic            RST;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_addr;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];

    rv32m_muldiv_unit #(.XLEN(XLEN)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request; returns right after the accept edge with start dropped
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge CLK);
        funct3  = f3;
        rs1_val = a;
        rs2_val = b;
        rd_addr = rd;
        start   = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen; an expired budget counts as a failed comparison
    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        while (cyc < 60) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        if (!done) check("done_timeout", 32'(cyc), 32'(XLEN + 1));
    endtask

    // Full operation with scoreboard: latency counted from the start cycle
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int cyc;
        bit busy_ok;
        exp_q.push_back(exp);
        issue(f3, a, b, rd);
        check({tag, "_busy_accept"}, 32'(busy), 32'd1);
        wait_done(cyc, busy_ok);
        check({tag, "_latency"}, 32'(cyc + 1), 32'd34);
        check({tag, "_busy_held"}, 32'(busy_ok & busy), 32'd1);
        check({tag, "_result"}, result, exp_q.pop_front());
        check({tag, "_rd_out"}, 32'(rd_out), 32'(rd));
        @(posedge CLK);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_clear"}, 32'(busy), 32'd0);
        check({tag, "_result_hold"}, result, exp);
    endtask

    initial begin
        int  cyc;
        bit  busy_ok;
        bit  saw_done;

        RST     = 1'b0;
        start   = 1'b0;
        funct3  = '0;
        rs1_val = '0;
        rs2_val = '0;
        rd_addr = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", result,      32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Multiply vectors
        run_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
        run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000);
        run_op("mulhu_ones",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
        run_op("mulhsu_ones",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF);
        run_op("mulhu_2p32",   3'd3, 32'h0001_0000,  32'h0001_0000, 5'd9,  32'h0000_0001);
        run_op("mul_2p32",     3'd0, 32'h0001_0000,  32'h0001_0000, 5'd10, 32'h0000_0000);

        // Divide vectors
        run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFD);
        run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         5'd12, 32'hFFFF_FFFF);
        run_op("div_m7_m2",    3'd4, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 5'd13, 32'd3);
        run_op("divu_100_7",   3'd5, 32'd100,        32'd7,         5'd14, 32'd14);
        run_op("remu_100_7",   3'd7, 32'd100,        32'd7,         5'd15, 32'd2);
        run_op("divu_min_m1",  3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0);
        run_op("remu_min_m1",  3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'h8000_0000);

        // Divide by zero and signed overflow
        run_op("div_42_0",     3'd4, 32'd42,         32'd0,         5'd18, 32'hFFFF_FFFF);
        run_op("divu_ff_0",    3'd5, 32'hFFFF_FFFF,  32'd0,         5'd19, 32'hFFFF_FFFF);
        run_op("remu_42_0",    3'd7, 32'd42,         32'd0,         5'd20, 32'd42);
        run_op("rem_m7_0",     3'd6, 32'hFFFF_FFF9,  32'd0,         5'd21, 32'hFFFF_FFF9);
        run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd22, 32'h8000_0000);
        run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd23, 32'd0);
        run_op("x0_dest",      3'd0, 32'd3,          32'd4,         5'd0,  32'd12);

        // start during CALC is ignored; a start held through DONE is taken only after IDLE
        exp_q.push_back(32'hFFFF_FFEB);
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        start   = 1'b1;
        funct3  = 3'd5;
        rs1_val = 32'd100;
        rs2_val = 32'd7;
        rd_addr = 5'd12;
        wait_done(cyc, busy_ok);
        check("ignore_result", result, exp_q.pop_front());
        check("ignore_rd_out", 32'(rd_out), 32'd9);
        @(posedge CLK);
        #1;
        check("no_accept_in_done", 32'(busy), 32'd0);
        @(posedge CLK);
        #1;
        check("accept_after_done", 32'(busy), 32'd1);
        start = 1'b0;
        exp_q.push_back(32'd14);
        wait_done(cyc, busy_ok);
        check("b2b_latency", 32'(cyc + 1), 32'd34);
        check("b2b_result", result, exp_q.pop_front());
        check("b2b_rd_out", 32'(rd_out), 32'd12);
        @(posedge CLK);

        // Asynchronous reset in the middle of a divide
        issue(3'd4, 32'd1000, 32'd3, 5'd25);
        repeat (9) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check("arst_busy",   32'(busy),   32'd0);
        check("arst_done",   32'(done),   32'd0);
        check("arst_result", result,      32'd0);
        check("arst_rd_out", 32'(rd_out), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("arst_no_done", 32'(saw_done), 32'd0);
        run_op("post_rst_div", 3'd4, 32'd1000, 32'd3, 5'd25, 32'd333);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
